// File: rtl/osd_candidate_buffer.sv
// Collects OSD test-error-pattern candidates from N_SRC ordered sources into one tagged buffer,
// then drains them as a valid/ready stream. First out_valid 1 cycle after the last in_done.
module osd_candidate_buffer #(
   parameter int K     = 8,
   parameter int N_SRC = 2,
   parameter int DEPTH = K + K*(K-1)/2,
   parameter int CW    = $clog2(DEPTH+1),
   parameter int TW    = $clog2(N_SRC+1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [N_SRC*K-1:0] in_data,
   input  logic [N_SRC-1:0]   in_valid,
   output logic [N_SRC-1:0]   in_ready,
   input  logic [N_SRC-1:0]   in_done,
   output logic [K-1:0]       out_data,
   output logic [TW-1:0]      out_order,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic [CW-1:0]      count,
   output logic               overflow,
   output logic               busy,
   output logic               done
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   typedef enum logic [1:0] {IDLE, ACC, DRAIN, FIN} state_t;
   state_t state, state_nxt;

   logic [K-1:0]  mem [DEPTH];
   logic [TW-1:0] tag [DEPTH];
   logic [CW-1:0] wr_ptr, rd_ptr, wr_ptr_inc;
   logic [SW-1:0] ch;
   logic          restart, accept, wr_en, src_done, last_src, xfer;

   assign restart    = start && (state == IDLE || state == FIN);
   assign accept     = (state == ACC) && in_valid[ch];
   assign wr_en      = accept && (wr_ptr < CW'(DEPTH));
   assign src_done   = (state == ACC) && in_done[ch];
   assign last_src   = (ch == SW'(N_SRC-1));
   assign wr_ptr_inc = wr_ptr + CW'(1);
   assign xfer       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (restart) state_nxt = ACC;
         ACC:   if (src_done && last_src) state_nxt = DRAIN;
         DRAIN: if (count == '0 || (xfer && out_last)) state_nxt = FIN;
         FIN:   if (restart) state_nxt = ACC;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == ACC) || (state == DRAIN);
      done      = (state == FIN);
      in_ready  = '0;
      if (state == ACC) in_ready = N_SRC'(1) << ch;
      out_valid = (state == DRAIN) && (rd_ptr < count);
      out_last  = out_valid && (rd_ptr == count - CW'(1));
      out_data  = '0;
      out_order = '0;
      if (out_valid) begin
         out_data  = mem[rd_ptr[AW-1:0]];
         out_order = tag[rd_ptr[AW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ch       <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (restart) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ch       <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr_inc;
         // Full buffer: keep draining the source but flag the loss.
         if (accept && !wr_en) overflow <= 1'b1;
         if (src_done) begin
            if (last_src) count <= wr_en ? wr_ptr_inc : wr_ptr;
            else          ch    <= ch + SW'(1);
         end
         if (xfer) rd_ptr <= rd_ptr + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= in_data[int'(ch)*K +: K];
         tag[wr_ptr[AW-1:0]] <= TW'(ch) + TW'(1);
      end
   end
endmodule

// File: tb/tb_osd_candidate_buffer.sv
// Directed bench for osd_candidate_buffer: full, overflow, empty, gating/backpressure, same-cycle done, reset/restart.
module tb_osd_candidate_buffer;
   localparam int K = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] in_data = '0;
   logic [1:0]  in_valid = '0;
   logic [1:0]  in_ready;
   logic [1:0]  in_done = '0;
   logic [7:0]  out_data;
   logic [1:0]  out_order;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_last;
   logic [5:0]  count;
   logic        overflow;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_d[$];
   logic [1:0] exp_o[$];

   osd_candidate_buffer dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_done(in_done),
      .out_data(out_data), .out_order(out_order), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last),
      .count(count), .overflow(overflow), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic beat(input logic [1:0] v, input logic [1:0] dn, input logic [15:0] d,
                       input logic [1:0] rdy_exp);
      @(negedge clk);
      in_valid = v; in_done = dn; in_data = d;
      #1 check("in_ready", 32'(in_ready), 32'(rdy_exp));
      @(posedge clk); #1;
      in_valid = '0; in_done = '0; in_data = '0;
   endtask

   task automatic src_beat(input int s, input logic [7:0] d, input bit last, input bit store);
      logic [1:0] sel;
      sel = 2'(1 << s);
      beat(sel, last ? sel : 2'b00, (s == 1) ? {d, 8'h00} : {8'h00, d}, sel);
      if (store) begin
         exp_d.push_back(d);
         exp_o.push_back(2'(s + 1));
      end
   endtask

   task automatic src_end(input int s);
      beat(2'b00, 2'(1 << s), 16'h0000, 2'(1 << s));
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_busy", 32'(busy), 1);
      check("start_done", 32'(done), 0);
      check("start_ovf", 32'(overflow), 0);
      check("start_count", 32'(count), 0);
   endtask

   // pat 0: always ready; pat 1: ready pattern 1,0,0,1,0,0,...
   task automatic drain(input int pat);
      int cyc;
      logic [7:0] held;
      bit have_held;
      logic [7:0] d;
      logic [1:0] o;
      cyc = 0;
      have_held = 0;
      while (exp_d.size() > 0 && cyc < 400) begin
         @(negedge clk);
         out_ready = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
         #1;
         if (cyc == 0) check("first_valid", 32'(out_valid), 1);
         if (have_held) begin
            check("stall_stable", 32'(out_data), 32'(held));
            have_held = 0;
         end
         if (out_valid) begin
            if (out_ready) begin
               d = exp_d.pop_front();
               o = exp_o.pop_front();
               check("drain_data", 32'(out_data), 32'(d));
               check("drain_order", 32'(out_order), 32'(o));
               check("drain_last", 32'(out_last), (exp_d.size() == 0) ? 1 : 0);
            end else begin
               held = out_data;
               have_held = 1;
            end
         end
         cyc++;
      end
      check("drain_left", exp_d.size(), 0);
      exp_d.delete();
      exp_o.delete();
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      check("drain_done", 32'(done), 1);
      check("drain_busy", 32'(busy), 0);
      check("drain_valid_after", 32'(out_valid), 0);
   endtask

   initial begin
      #12;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_ready", 32'(in_ready), 0);
      check("rst_count", 32'(count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      check("idle_ready", 32'(in_ready), 0);

      // Full run: 8 order-1 then 28 order-2 candidates.
      do_start();
      for (int i = 0; i < 8; i++)  src_beat(0, 8'(8'h10 + i), i == 7, 1);
      for (int i = 0; i < 28; i++) src_beat(1, 8'(8'h80 + i), i == 27, 1);
      check("full_count", 32'(count), 36);
      check("full_ovf", 32'(overflow), 0);
      drain(0);

      // Overflow: empty src0, 40 beats on src1, last 4 dropped.
      do_start();
      src_end(0);
      for (int i = 0; i < 40; i++) src_beat(1, 8'(8'h40 + i), i == 39, i < 36);
      check("ovf_count", 32'(count), 36);
      check("ovf_flag", 32'(overflow), 1);
      drain(0);

      // Empty run.
      do_start();
      src_end(0);
      src_end(1);
      check("empty_count", 32'(count), 0);
      check("empty_valid", 32'(out_valid), 0);
      check("empty_done_early", 32'(done), 0);
      @(posedge clk); #1;
      check("empty_done", 32'(done), 1);
      check("empty_valid2", 32'(out_valid), 0);

      // Gating and backpressure.
      do_start();
      beat(2'b11, 2'b00, 16'hEE11, 2'b01);
      exp_d.push_back(8'h11); exp_o.push_back(2'd1);
      src_beat(0, 8'h22, 1, 1);
      beat(2'b01, 2'b01, 16'h0099, 2'b10);
      src_beat(1, 8'h33, 0, 1);
      src_beat(1, 8'h44, 1, 1);
      check("gate_count", 32'(count), 4);
      drain(1);

      // Same-cycle valid and done.
      do_start();
      src_beat(0, 8'hA5, 1, 1);
      src_end(1);
      check("same_count", 32'(count), 1);
      drain(0);

      // Reset mid-drain, then restart.
      do_start();
      src_beat(0, 8'h01, 1, 0);
      src_beat(1, 8'h02, 1, 0);
      check("pre_rst_valid", 32'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 0);
      check("arst_data", 32'(out_data), 0);
      check("arst_order", 32'(out_order), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_count", 32'(count), 0);
      check("arst_last", 32'(out_last), 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_start();
      src_beat(0, 8'hC1, 0, 1);
      src_beat(0, 8'hC2, 1, 1);
      src_beat(1, 8'hC3, 1, 1);
      check("restart_count", 32'(count), 3);
      check("restart_ovf", 32'(overflow), 0);
      drain(0);

      // Second start straight from the finished state.
      do_start();
      src_beat(0, 8'h5A, 1, 1);
      src_beat(1, 8'h6B, 1, 1);
      check("rerun_count", 32'(count), 2);
      drain(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
